// File: rtl/ram8.sv
// ram8: eight-word register file; a 3-level dmux1_2 tree steers load, an 8-to-1 mux reads.
// Define RAM8_REGOUT_EN to register the read data (1-cycle read latency).
module ram8 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic [2:0]       address,
  input  logic             load,
  output logic [WIDTH-1:0] out,
  output logic [7:0]       load_vec
);

  logic [1:0]       lvl1;
  logic [3:0]       lvl2;
  logic [WIDTH-1:0] mem_q [8];
  logic [WIDTH-1:0] mem_d [8];
  logic [WIDTH-1:0] rd_d;

  // 1-to-2 demux: AND-gating keeps the outputs 0 when load is 0, even if sel is X.
  function automatic logic [1:0] dmux1_2(input logic d, input logic sel);
    dmux1_2 = {d & sel, d & ~sel};
  endfunction

  always_comb begin
    lvl1     = dmux1_2(load, address[2]);
    lvl2     = '0;
    load_vec = '0;
    for (int i = 0; i < 2; i++) begin
      lvl2[2*i +: 2] = dmux1_2(lvl1[i], address[1]);
    end
    for (int j = 0; j < 4; j++) begin
      load_vec[2*j +: 2] = dmux1_2(lvl2[j], address[0]);
    end
  end

  always_comb begin
    for (int k = 0; k < 8; k++) begin
      mem_d[k] = load_vec[k] ? in : mem_q[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 8; k++) begin
        mem_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 8; k++) begin
        mem_q[k] <= mem_d[k];
      end
    end
  end

  assign rd_d = mem_q[address];

`ifdef RAM8_REGOUT_EN
  logic [WIDTH-1:0] out_q;

  // Samples the pre-edge contents, so a same-address write shows up one edge later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
    end else begin
      out_q <= rd_d;
    end
  end

  assign out = out_q;
`else
  assign out = rd_d;
`endif

endmodule

// File: tb/tb_ram8.sv
// tb_ram8: directed bench for ram8 with a scoreboard queue of expected read data.
// Honours RAM8_REGOUT_EN by waiting one extra edge before each read comparison.
module tb_ram8;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] inData;
  logic [2:0]   address;
  logic         load;
  logic [W-1:0] outData;
  logic [7:0]   loadVec;

  int vectors     = 0;
  int miscompares = 0;

  logic [W-1:0] expQ [$];
  string        tagQ [$];
  logic [W-1:0] model [8];

  always #5 clk = ~clk;

  ram8 #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in      (inData),
    .address (address),
    .load    (load),
    .out     (outData),
    .load_vec(loadVec)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic l, input logic [2:0] a, input logic [W-1:0] d);
    load    = l;
    address = a;
    inData  = d;
  endtask

  task automatic expectOut(input string tag, input logic [W-1:0] e);
    tagQ.push_back(tag);
    expQ.push_back(e);
  endtask

  task automatic checkOutput();
    logic [W-1:0] e;
    string        tag;
    vectors++;
    if (expQ.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty: out=%h expected none", outData);
    end else begin
      e   = expQ.pop_front();
      tag = tagQ.pop_front();
      assert (outData === e) else begin
        miscompares++;
        $error("FAIL %s: out=%h expected %h", tag, outData, e);
      end
    end
  endtask

  task automatic checkVec(input string tag, input logic [7:0] e);
    vectors++;
    assert (loadVec === e) else begin
      miscompares++;
      $error("FAIL %s: load_vec=%h expected %h", tag, loadVec, e);
    end
  endtask

  task automatic writeWord(input logic [2:0] a, input logic [W-1:0] d);
    applyStimulus(1'b1, a, d);
    tick();
    model[a] = d;
    load     = 1'b0;
  endtask

  task automatic readWord(input logic [2:0] a, input string tag);
    applyStimulus(1'b0, a, '0);
    expectOut(tag, model[a]);
`ifdef RAM8_REGOUT_EN
    tick();
`else
    #1;
`endif
    checkOutput();
  endtask

  task automatic readAll(input string tag);
    for (int k = 0; k < 8; k++) begin
      readWord(k[2:0], $sformatf("%s_a%0d", tag, k));
    end
  endtask

  task automatic clearModel();
    for (int k = 0; k < 8; k++) model[k] = '0;
  endtask

  initial begin
    rst_n = 1'b1;
    applyStimulus(1'b0, 3'd0, '0);
    clearModel();
    #2 rst_n = 1'b0;
    #1;
    expectOut("reset_out", '0);
    checkOutput();
    checkVec("reset_vec", 8'h00);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Make out non-zero, then assert reset mid-cycle while a load is pending.
    writeWord(3'd0, 16'h7777);
    readWord(3'd0, "pre_reset");
    applyStimulus(1'b1, 3'd0, 16'hFFFF);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    expectOut("reset_async", '0);
    checkOutput();
    tick();
    load = 1'b0;
    rst_n = 1'b1;
    clearModel();
    tick();
    readAll("after_reset");

    // Decode sweep combined with the fill.
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, k[2:0], 16'h1000 + W'(k));
      #1;
      checkVec($sformatf("decode_a%0d", k), 8'h01 << k);
      tick();
      model[k] = 16'h1000 + W'(k);
    end
    applyStimulus(1'b0, 3'd6, 16'hDEAD);
    #1;
    checkVec("decode_noload", 8'h00);

    // Unknown address and data with load low must not disturb any word.
    applyStimulus(1'b0, 3'bxxx, 'x);
    #1;
    checkVec("decode_xaddr", 8'h00);
    tick();
    tick();
    readAll("fill");

    writeWord(3'd3, 16'hBEEF);
    writeWord(3'd4, 16'h1234);
    readAll("isolation");

    // Read during write at the same address.
    writeWord(3'd5, 16'h00AA);
    readWord(3'd5, "rdw_setup");
    applyStimulus(1'b1, 3'd5, 16'h5555);
    #1;
    expectOut("rdw_before", 16'h00AA);
    checkOutput();
    tick();
    load     = 1'b0;
    model[5] = 16'h5555;
`ifdef RAM8_REGOUT_EN
    expectOut("rdw_pipe", 16'h00AA);
    checkOutput();
    tick();
`endif
    expectOut("rdw_after", 16'h5555);
    checkOutput();

    // Back-to-back burst with reset landing on the third write.
    writeWord(3'd0, 16'hA000);
    writeWord(3'd1, 16'hA001);
    applyStimulus(1'b1, 3'd2, 16'hA002);
    rst_n = 1'b0;
    tick();
    load = 1'b0;
    clearModel();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    readAll("burst_reset");

    if (expQ.size() != 0) begin
      miscompares++;
      $error("FAIL scoreboard_leftover: pending=%0d expected 0", expQ.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: sim time exceeded limit");
    $fatal(1, "timeout");
  end
endmodule
